// File: rtl/des288_capture_buf.sv
// Triggered snapshot buffer for the 288-bit deserializer output, drained by a host read port.
// Optional pre-trigger ring capture: define CAPTURE_PRETRIG_EN.
module des288_lane #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Registered read sees the pre-write contents on a same-address collision.
  always_ff @(posedge clk or posedge rst)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

module des288_capture_buf #(
  parameter int LANES   = 32,
  parameter int WIDTH   = 9,
  parameter int DEPTH   = 256,
  parameter int PRE_LEN = 64,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig,
  input  logic [AW:0]            cap_len,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [LANES*WIDTH-1:0] rd_data,
  output logic                   rd_valid,
  output logic [1:0]             state,
  output logic                   done,
  output logic [AW-1:0]          trig_addr
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} st_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  if (DEPTH < 4 || DEPTH > 4096 || (1 << AW) != DEPTH || PRE_LEN < 1 || PRE_LEN >= DEPTH) begin : g_bad_cfg
    $error("des288_capture_buf: bad DEPTH/PRE_LEN");
  end

  st_e           st, st_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n, waddr, tadr_n;
  logic [AW:0]   post_cnt, post_n, len_q, len_n, eff_len;
  logic          we, rd_vld_q;

  logic [LANES-1:0][WIDTH-1:0] in_lanes, rd_lanes;
  assign in_lanes = in_data;
  assign rd_data  = rd_lanes;

  assign eff_len = (cap_len == '0 || cap_len > DEPTH_W) ? DEPTH_W : cap_len;

`ifdef CAPTURE_PRETRIG_EN
  localparam logic [AW:0] PRE_W    = (AW+1)'(PRE_LEN);
  localparam logic [AW:0] POST_LEN = (AW+1)'(DEPTH - PRE_LEN);
  logic [AW:0] fill, fill_n;
`endif

  always_comb begin
    st_n     = st;
    we       = 1'b0;
    waddr    = wr_ptr;
    wr_ptr_n = wr_ptr;
    post_n   = post_cnt;
    len_n    = len_q;
    tadr_n   = trig_addr;
`ifdef CAPTURE_PRETRIG_EN
    fill_n   = fill;
`endif
    if (abort) begin
      st_n = IDLE;
    end else if (arm) begin
      st_n     = ARMED;
      wr_ptr_n = '0;
      post_n   = '0;
`ifdef CAPTURE_PRETRIG_EN
      fill_n   = '0;
`endif
    end else begin
      case (st)
        ARMED: begin
`ifdef CAPTURE_PRETRIG_EN
          // Ring keeps running; trigger needs PRE_LEN history words already stored.
          if (in_valid) begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            if (fill != DEPTH_W) fill_n = fill + 1'b1;
            if (trig && fill >= PRE_W) begin
              tadr_n = wr_ptr;
              post_n = (AW+1)'(1);
              len_n  = POST_LEN;
              st_n   = (POST_LEN == (AW+1)'(1)) ? DONE : CAPTURE;
            end
          end
`else
          if (in_valid && trig) begin
            we       = 1'b1;
            waddr    = '0;
            wr_ptr_n = AW'(1);
            post_n   = (AW+1)'(1);
            tadr_n   = '0;
            len_n    = eff_len;
            st_n     = (eff_len == (AW+1)'(1)) ? DONE : CAPTURE;
          end
`endif
        end
        CAPTURE: begin
          if (in_valid) begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            post_n   = post_cnt + 1'b1;
            if (post_n == len_q) st_n = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      post_cnt  <= '0;
      len_q     <= '0;
      trig_addr <= '0;
      rd_vld_q  <= 1'b0;
`ifdef CAPTURE_PRETRIG_EN
      fill      <= '0;
`endif
    end else begin
      st        <= st_n;
      wr_ptr    <= wr_ptr_n;
      post_cnt  <= post_n;
      len_q     <= len_n;
      trig_addr <= tadr_n;
      rd_vld_q  <= rd_en;
`ifdef CAPTURE_PRETRIG_EN
      fill      <= fill_n;
`endif
    end
  end

  assign state    = st;
  assign done     = (st == DONE);
  assign rd_valid = rd_vld_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    des288_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (waddr),
      .wdata (in_lanes[k]),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_lanes[k])
    );
  end
endmodule

// File: tb/tb_des288_capture_buf.sv
// Directed bench for des288_capture_buf: reset, capture lengths, gapped input, abort, read-first, pre-trigger ring.
module tb_des288_capture_buf;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [287:0] in_data = '0;
  logic         arm = 1'b0, abort = 1'b0, trig = 1'b0;
  logic [8:0]   cap_len = '0;
  logic         rd_en = 1'b0;
  logic [7:0]   rd_addr = '0;
  logic [287:0] rd_data;
  logic         rd_valid;
  logic [1:0]   state;
  logic         done;
  logic [7:0]   trig_addr;
  int checks = 0, errors = 0;

  des288_capture_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .arm(arm), .abort(abort),
    .trig(trig), .cap_len(cap_len), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .state(state), .done(done), .trig_addr(trig_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [287:0] ramp(input int n);
    logic [287:0] w;
    for (int k = 0; k < 32; k++) w[9*k +: 9] = 9'((n + k) % 512);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a);
    rd_en   = 1'b1;
    rd_addr = 8'(a);
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic do_arm(input int len);
    cap_len  = 9'(len);
    arm      = 1'b1;
    in_valid = 1'b0;
    trig     = 1'b0;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    int m;
    // reset
    tick(); tick();
    chk("rst_state", 288'(state), 288'(0));
    chk("rst_done", 288'(done), 288'(0));
    chk("rst_rd_valid", 288'(rd_valid), 288'(0));
    chk("rst_rd_data", rd_data, 288'(0));
    chk("rst_trig_addr", 288'(trig_addr), 288'(0));
    rst = 1'b0;
    tick();

`ifdef CAPTURE_PRETRIG_EN
    do_arm(16);
    chk("pt_armed", 288'(state), 288'(1));
    for (int n = 0; n < 494; n++) begin
      in_valid = 1'b1;
      in_data  = ramp(n);
      trig     = (n == 20 || n == 300);
      tick();
      if (n == 20)  chk("pt_early_trig", 288'(state), 288'(1));
      if (n == 300) chk("pt_trig_state", 288'(state), 288'(2));
      if (n == 300) chk("pt_trig_addr", 288'(trig_addr), 288'(44));
      if (n == 490) chk("pt_cap_190", 288'(state), 288'(2));
      if (n == 491) chk("pt_done", 288'(state), 288'(3));
    end
    in_valid = 1'b0; trig = 1'b0;
    chk("pt_done_hold", 288'(state), 288'(3));
    rd(236); chk("pt_oldest", rd_data, ramp(236));
    rd(44);  chk("pt_trig_word", rd_data, ramp(300));
    rd(235); chk("pt_last_word", rd_data, ramp(491));
    rd(237); chk("pt_old_237", rd_data, ramp(237));
`else
    // cap_len=16 ramp capture, trigger on n=10
    do_arm(16);
    chk("t2_armed", 288'(state), 288'(1));
    for (int n = 0; n < 28; n++) begin
      in_valid = 1'b1;
      in_data  = ramp(n);
      trig     = (n == 10);
      tick();
      if (n == 9)  chk("t2_pre_trig", 288'(state), 288'(1));
      if (n == 10) chk("t2_capture", 288'(state), 288'(2));
      if (n == 24) chk("t2_cap_15", 288'(state), 288'(2));
      if (n == 25) chk("t2_done", 288'(state), 288'(3));
    end
    in_valid = 1'b0; trig = 1'b0;
    chk("t2_done_flag", 288'(done), 288'(1));
    chk("t2_trig_addr", 288'(trig_addr), 288'(0));
    for (int i = 0; i < 16; i++) begin
      rd(i);
      chk($sformatf("t2_rd%0d", i), rd_data, ramp(10 + i));
    end
    chk("t2_rd_valid", 288'(rd_valid), 288'(1));

    // cap_len=0 -> full DEPTH, gapped input, trig held high
    do_arm(0);
    m = 0;
    trig = 1'b1;
    for (int c = 0; c < 1000 && m < 256; c++) begin
      in_valid = (c % 3 == 0);
      in_data  = in_valid ? ramp(1000 + m) : ramp(7777);
      tick();
      if (in_valid) m++;
      if (in_valid && m == 255) chk("t3_cap_255", 288'(state), 288'(2));
    end
    chk("t3_word_count", 288'(m), 288'(256));
    chk("t3_done", 288'(state), 288'(3));
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_data = ramp(5555); tick();
    end
    in_valid = 1'b0; trig = 1'b0;
    chk("t3_done_hold", 288'(state), 288'(3));
    for (int i = 0; i < 256; i++) begin
      rd(i);
      chk($sformatf("t3_rd%0d", i), rd_data, ramp(1000 + i));
    end

    // abort at post_cnt=5, then arm+trig together, cap_len=4
    do_arm(16);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = ramp(2000 + i); trig = (i == 0); tick();
    end
    chk("t4_pre_abort", 288'(state), 288'(2));
    abort = 1'b1; in_valid = 1'b1; in_data = ramp(6666); trig = 1'b0;
    tick();
    abort = 1'b0;
    chk("t4_abort_idle", 288'(state), 288'(0));
    chk("t4_abort_done", 288'(done), 288'(0));
    cap_len = 9'd4; arm = 1'b1; trig = 1'b1; in_valid = 1'b1; in_data = ramp(9999);
    tick();
    arm = 1'b0;
    chk("t4_arm_wins", 288'(state), 288'(1));
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = ramp(3000 + i); trig = (i == 0); tick();
      if (i == 2) chk("t4_cap", 288'(state), 288'(2));
    end
    in_valid = 1'b0; trig = 1'b0;
    chk("t4_done", 288'(state), 288'(3));
    for (int i = 0; i < 4; i++) begin
      rd(i);
      chk($sformatf("t4_rd%0d", i), rd_data, ramp(3000 + i));
      chk($sformatf("t4_vld%0d", i), 288'(rd_valid), 288'(1));
    end
    rd(4); chk("t4_rd4", rd_data, ramp(2004));
    rd(5); chk("t4_abort_nowrite", rd_data, ramp(1005));
    tick();
    chk("t4_vld_drop", 288'(rd_valid), 288'(0));
    chk("t4_rd_hold", rd_data, ramp(1005));

    // read-first collision on addr 3 during capture
    do_arm(8);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = ramp(4000 + i); trig = (i == 0); tick();
    end
    trig = 1'b0; in_valid = 1'b1; in_data = ramp(4003);
    rd_en = 1'b1; rd_addr = 8'd3;
    tick();
    rd_en = 1'b0; in_valid = 1'b0;
    chk("t5_read_first", rd_data, ramp(3003));
    rd(3); chk("t5_new_data", rd_data, ramp(4003));
    for (int i = 4; i < 8; i++) begin
      in_valid = 1'b1; in_data = ramp(4000 + i); tick();
    end
    in_valid = 1'b0;
    chk("t5_done", 288'(state), 288'(3));

    // cap_len=1: trigger word alone completes the capture
    do_arm(1);
    in_valid = 1'b1; trig = 1'b1; in_data = ramp(123);
    tick();
    in_valid = 1'b0; trig = 1'b0;
    chk("t6_len1_done", 288'(state), 288'(3));
    rd(0); chk("t6_len1_data", rd_data, ramp(123));
    rd(1); chk("t6_len1_untouched", rd_data, ramp(4001));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
